// File: rtl/wb_pkg.sv
// Shared write-back definitions: pipeline result source selector codes.
package wb_pkg;

    // Source of the single-cycle pipeline result; NONE means no register write.
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_NONE = 2'b11
    } wb_sel_e;

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant among req, search starts at ptr.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] idx;
    logic            found;

    // Find the first requester at or after ptr; advance ptr past the winner.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        if (en) begin
            for (int k = 0; k < int'(N); k++) begin
                idx = PtrW'((int'(ptr_q) + k) % int'(N));
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    ptr_d      = PtrW'((int'(ptr_q) + k + 1) % int'(N));
                end
            end
        end
    end

    // Pointer register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back stage: pipeline results win; multi-cycle results are parked in
// one-entry buffers and drained round-robin when the pipeline is idle.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned N_MC = 2,
    parameter int unsigned RA_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic [1:0]           ex_sel,
    input  logic [RA_W-1:0]      ex_rd,
    input  logic [XLEN-1:0]      ex_alu,
    input  logic [XLEN-1:0]      ex_load,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic [N_MC-1:0]      mc_valid,
    output logic [N_MC-1:0]      mc_ready,
    input  logic [N_MC*RA_W-1:0] mc_rd,
    input  logic [N_MC*XLEN-1:0] mc_data,
    output logic                 wb_we,
    output logic [RA_W-1:0]      wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic [N_MC-1:0]      mc_pend,
    output logic [N_MC*RA_W-1:0] mc_pend_rd
);

    logic [N_MC-1:0]      buf_full_q, buf_full_d;
    logic [N_MC*RA_W-1:0] buf_rd_q;
    logic [N_MC*XLEN-1:0] buf_data_q;
    logic [N_MC-1:0]      grant;
    logic [N_MC-1:0]      accept;
    logic [N_MC-1:0]      load;

    logic                 ex_write;
    logic [XLEN-1:0]      ex_result;

    logic                 wb_we_q, wb_we_d;
    logic [RA_W-1:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]      wb_data_q, wb_data_d;

    // Pipeline write decode and source mux.
    always_comb begin
        ex_write  = ex_valid && (wb_sel_e'(ex_sel) != WB_SEL_NONE) && (ex_rd != '0);
        ex_result = ex_alu;
        case (wb_sel_e'(ex_sel))
            WB_SEL_ALU:  ex_result = ex_alu;
            WB_SEL_LOAD: ex_result = ex_load;
            WB_SEL_PC4:  ex_result = ex_pc + XLEN'(4);
            default:     ex_result = ex_alu;
        endcase
    end

    rr_arbiter #(
        .N(N_MC)
    ) u_rr (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (buf_full_q),
        .en   (!ex_write),
        .grant(grant)
    );

    // Handshake: a buffer being drained this cycle can accept a refill.
    always_comb begin
        mc_ready   = ~buf_full_q | grant;
        accept     = mc_valid & mc_ready;
        load       = '0;
        buf_full_d = buf_full_q & ~grant;
        for (int i = 0; i < int'(N_MC); i++) begin
            // rd==0 results are consumed but never parked.
            load[i] = accept[i] && (mc_rd[i*RA_W +: RA_W] != '0);
        end
        buf_full_d = buf_full_d | load;
    end

    // Per-channel result buffers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_full_q <= '0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            for (int i = 0; i < int'(N_MC); i++) begin
                if (load[i]) begin
                    buf_rd_q[i*RA_W +: RA_W]   <= mc_rd[i*RA_W +: RA_W];
                    buf_data_q[i*XLEN +: XLEN] <= mc_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Next write-port value: pipeline first, then the granted buffer, else hold.
    always_comb begin
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (ex_write) begin
            wb_we_d   = 1'b1;
            wb_rd_d   = ex_rd;
            wb_data_d = ex_result;
        end else begin
            for (int i = 0; i < int'(N_MC); i++) begin
                if (grant[i]) begin
                    wb_we_d   = 1'b1;
                    wb_rd_d   = buf_rd_q[i*RA_W +: RA_W];
                    wb_data_d = buf_data_q[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign mc_pend    = buf_full_q;
    assign mc_pend_rd = buf_rd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes are queued by stimulus and
// popped by a monitor on every wb_we pulse.
module tb_wb_arbiter;

    localparam int XLEN = 32;
    localparam int N_MC = 2;
    localparam int RA_W = 5;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ex_valid;
    logic [1:0]           ex_sel;
    logic [RA_W-1:0]      ex_rd;
    logic [XLEN-1:0]      ex_alu, ex_load, ex_pc;
    logic [N_MC-1:0]      mc_valid;
    logic [N_MC-1:0]      mc_ready;
    logic [N_MC*RA_W-1:0] mc_rd;
    logic [N_MC*XLEN-1:0] mc_data;
    logic                 wb_we;
    logic [RA_W-1:0]      wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic [N_MC-1:0]      mc_pend;
    logic [N_MC*RA_W-1:0] mc_pend_rd;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];

    wb_arbiter #(.XLEN(XLEN), .N_MC(N_MC), .RA_W(RA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_sel    (ex_sel),
        .ex_rd     (ex_rd),
        .ex_alu    (ex_alu),
        .ex_load   (ex_load),
        .ex_pc     (ex_pc),
        .mc_valid  (mc_valid),
        .mc_ready  (mc_ready),
        .mc_rd     (mc_rd),
        .mc_data   (mc_data),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .mc_pend   (mc_pend),
        .mc_pend_rd(mc_pend_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [RA_W-1:0] rd, input logic [XLEN-1:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic set_ex(input logic v, input logic [1:0] sel, input logic [RA_W-1:0] rd,
                          input logic [XLEN-1:0] alu);
        ex_valid = v;
        ex_sel   = sel;
        ex_rd    = rd;
        ex_alu   = alu;
    endtask

    task automatic set_mc(input int ch, input logic v, input logic [RA_W-1:0] rd,
                          input logic [XLEN-1:0] data);
        mc_valid[ch]               = v;
        mc_rd[ch*RA_W +: RA_W]     = rd;
        mc_data[ch*XLEN +: XLEN]   = data;
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write",
                         wb_rd, wb_data);
            end else begin
                e = exp_q.pop_front();
                if (wb_rd !== e.rd || wb_data !== e.data) begin
                    errors++;
                    $display("FAIL write_order: got rd=%0d data=%0h expected rd=%0d data=%0h",
                             wb_rd, wb_data, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        set_ex(1'b0, 2'b11, '0, '0);
        ex_load  = '0;
        ex_pc    = '0;
        mc_valid = '0;
        mc_rd    = '0;
        mc_data  = '0;
        cyc();
        cyc();
        rst_n = 1'b1;

        // Reset state.
        chk("reset_we", 64'(wb_we), 64'd0);
        chk("reset_rd", 64'(wb_rd), 64'd0);
        chk("reset_data", 64'(wb_data), 64'd0);
        chk("reset_pend", 64'(mc_pend), 64'd0);
        chk("reset_pend_rd", 64'(mc_pend_rd), 64'd0);
        chk("reset_ready", 64'(mc_ready), 64'h3);

        // Reset mid-stream: park 0xDEAD behind a pipeline write, then reset.
        set_ex(1'b1, 2'b00, 5'd1, 32'hAA);
        set_mc(0, 1'b1, 5'd5, 32'hDEAD);
        push(5'd1, 32'hAA);
        cyc();
        set_mc(0, 1'b0, 5'd0, 32'h0);
        set_ex(1'b0, 2'b11, 5'd0, 32'h0);
        chk("midrst_pend_before", 64'(mc_pend[0]), 64'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_we", 64'(wb_we), 64'd0);
        chk("midrst_pend", 64'(mc_pend), 64'd0);
        repeat (4) cyc();

        // Pipeline sources.
        set_ex(1'b1, 2'b00, 5'd1, 32'h11);
        push(5'd1, 32'h11);
        cyc();
        chk("alu_we", 64'(wb_we), 64'd1);
        ex_sel = 2'b01; ex_rd = 5'd2; ex_load = 32'h22;
        push(5'd2, 32'h22);
        cyc();
        ex_sel = 2'b10; ex_rd = 5'd3; ex_pc = 32'hFFFF_FFFC;
        push(5'd3, 32'h0);
        cyc();
        chk("pc4_wrap", 64'(wb_data), 64'd0);
        ex_sel = 2'b11; ex_rd = 5'd4;
        cyc();
        chk("sel_none_no_we", 64'(wb_we), 64'd0);
        set_ex(1'b1, 2'b00, 5'd0, 32'h55);
        cyc();
        chk("rd0_no_we", 64'(wb_we), 64'd0);
        set_ex(1'b0, 2'b11, 5'd0, 32'h0);
        cyc();

        // Collision: pipeline busy 3 cycles while mc0 delivers rd 7.
        set_ex(1'b1, 2'b00, 5'd10, 32'h10);
        set_mc(0, 1'b1, 5'd7, 32'h77);
        push(5'd10, 32'h10);
        chk("coll_ready_empty", 64'(mc_ready[0]), 64'd1);
        cyc();
        set_mc(0, 1'b0, 5'd0, 32'h0);
        set_ex(1'b1, 2'b00, 5'd11, 32'h1011);
        push(5'd11, 32'h1011);
        chk("coll_ready_full", 64'(mc_ready[0]), 64'd0);
        chk("coll_pend", 64'(mc_pend[0]), 64'd1);
        chk("coll_pend_rd", 64'(mc_pend_rd[RA_W-1:0]), 64'd7);
        cyc();
        set_ex(1'b1, 2'b00, 5'd12, 32'h1012);
        push(5'd12, 32'h1012);
        cyc();
        set_ex(1'b0, 2'b11, 5'd0, 32'h0);
        push(5'd7, 32'h77);
        cyc();
        chk("coll_drain_we", 64'(wb_we), 64'd1);
        chk("coll_drain_rd", 64'(wb_rd), 64'd7);
        chk("coll_pend_fall", 64'(mc_pend), 64'd0);
        cyc();

        // Round-robin from ptr=0 (reset clears ptr).
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            set_ex(1'b1, 2'b00, 5'd13, 32'h13);
            set_mc(0, 1'b1, 5'd8, 32'h80);
            set_mc(1, 1'b1, 5'd9, 32'h90);
            push(5'd13, 32'h13);
            cyc();
            set_ex(1'b0, 2'b11, 5'd0, 32'h0);
            mc_valid = '0;
            chk("rr_both_pend", 64'(mc_pend), 64'h3);
            push(5'd8, 32'h80);
            push(5'd9, 32'h90);
            cyc();
            chk("rr_first_rd8", 64'(wb_rd), 64'd8);
            cyc();
            chk("rr_second_rd9", 64'(wb_rd), 64'd9);
        end
        // Single grant to channel 0 moves ptr to 1.
        set_mc(0, 1'b1, 5'd20, 32'h20);
        push(5'd20, 32'h20);
        cyc();
        mc_valid = '0;
        cyc();
        set_ex(1'b1, 2'b00, 5'd13, 32'h13);
        set_mc(0, 1'b1, 5'd8, 32'h80);
        set_mc(1, 1'b1, 5'd9, 32'h90);
        push(5'd13, 32'h13);
        cyc();
        set_ex(1'b0, 2'b11, 5'd0, 32'h0);
        mc_valid = '0;
        push(5'd9, 32'h90);
        push(5'd8, 32'h80);
        cyc();
        chk("rr_ptr1_first_rd9", 64'(wb_rd), 64'd9);
        cyc();
        chk("rr_ptr1_second_rd8", 64'(wb_rd), 64'd8);
        cyc();

        // Back-to-back on channel 0, pipeline idle.
        for (int i = 0; i < 6; i++) begin
            set_mc(0, 1'b1, 5'(14 + i), 32'h100 + 32'(i));
            push(5'(14 + i), 32'h100 + 32'(i));
            chk("b2b_ready", 64'(mc_ready[0]), 64'd1);
            cyc();
        end
        mc_valid = '0;
        repeat (3) cyc();

        // rd=0 multi-cycle result: accepted, never parked or written.
        set_mc(1, 1'b1, 5'd0, 32'h99);
        chk("rd0_mc_ready", 64'(mc_ready[1]), 64'd1);
        cyc();
        mc_valid = '0;
        chk("rd0_mc_pend", 64'(mc_pend), 64'd0);
        repeat (4) cyc();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
